// File: rtl/bitsplit_pkg.sv
// Shared definitions for the 2-bit swapped-lane link (transmit and receive sides).
package bitsplit_pkg;

    localparam int BSYM_W = 2;

    typedef logic [BSYM_W-1:0] bsym_t;

    // Swapping the two lanes is its own inverse, so the transmit side reuses this.
    function automatic bsym_t bsym_unswap(input bsym_t sym);
        return {sym[0], sym[1]};
    endfunction

endpackage

// File: rtl/bitsplit_out_reg.sv
// WIDTH-bit valid/ready holding register: loads a completed word and holds it
// until consumed; a load in the same cycle as a consume replaces the word without a bubble.
module bitsplit_out_reg
    import bitsplit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] outvec
);

    // NOTE: reset is synchronous (sampled only on clk), and all state uses <= so
    // every register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            out_valid <= 1'b0;
            outvec    <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            outvec    <= load_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/bitsplit_deser.sv
// Receive-side decoder: un-swaps each 2-bit symbol and packs WIDTH/2 of them into
// one word presented on a valid/ready port; sof restarts packing and flags a drop.
module bitsplit_deser
    import bitsplit_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       invec,
    input  logic             sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] outvec,
    output logic             drop
);

    localparam int N     = WIDTH / BSYM_W;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
        $error("bitsplit_deser: WIDTH must be even and >= 4");
    end

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] merged;
    logic [CNT_W-1:0] slot;
    bsym_t            sym;
    logic             at_last;
    logic             accept;
    logic             complete;

    assign sym     = bsym_unswap(invec);
    assign at_last = (cnt == LAST);

    // Only the completing symbol can stall, and only behind a word still held.
    assign in_ready = reset_l && !(at_last && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    // An sof symbol is always symbol 0, so it can never complete a word.
    assign complete = accept && !sof && at_last;

    // NOTE: every variable written here gets its default first, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        slot   = sof ? '0 : cnt;
        merged = sof ? '0 : acc;
        for (int i = 0; i < N; i++) begin
            if (slot == CNT_W'(i)) begin
                if (MSB_FIRST) begin
                    merged[WIDTH-BSYM_W-BSYM_W*i +: BSYM_W] = sym;
                end else begin
                    merged[BSYM_W*i +: BSYM_W] = sym;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_l) begin
            cnt  <= '0;
            acc  <= '0;
            drop <= 1'b0;
        end else begin
            drop <= accept && sof && (cnt != '0);
            if (accept) begin
                if (sof) begin
                    cnt <= CNT_W'(1);
                    acc <= merged;
                end else if (at_last) begin
                    cnt <= '0;
                    acc <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                    acc <= merged;
                end
            end
        end
    end

    bitsplit_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk      (clk),
        .reset_l  (reset_l),
        .load     (complete),
        .load_data(merged),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .outvec   (outvec)
    );

endmodule
